// File: rtl/hazard_pkg.sv
// Shared op-class and forward-select encodings plus the shadow pipeline entry.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } optype_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EX    = 2'b01;
    localparam logic [1:0] FWD_MEM   = 2'b10;
    localparam logic [1:0] FWD_MEMLD = 2'b11;

    typedef struct packed {
        optype_e                 optype;
        logic [REG_AW_DEF-1:0]   rd;
        logic [REG_AW_DEF-1:0]   rs2;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '{optype: OP_NONE, rd: '0, rs2: '0};

    function automatic logic is_writer(input logic [1:0] op);
        return (op == OP_ALU) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// ID-stage operand source select for one register read port.
// Purely combinational; no flow control of its own.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [1:0]        ex_op,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [1:0]        mem_op,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = (rs != '0) && is_writer(ex_op)  && (ex_rd  == rs);
    assign mem_hit = (rs != '0) && is_writer(mem_op) && (mem_rd == rs);

    // A load still in EX has no data yet: it shadows any older MEM match and
    // leaves the regfile path selected (stall or late store fix-up covers it).
    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = (ex_op == OP_ALU) ? FWD_EX : FWD_RF;
        end else if (mem_hit) begin
            sel = (mem_op == OP_ALU) ? FWD_MEM : FWD_MEMLD;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler: shadows EX/MEM/WB, drives stall/flush/enable and forward selects.
// Outputs are combinational from ID inputs + shadow; a pending data-memory access freezes everything.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [1:0]        hazard_optype_ID,
    input  logic              Branch_ID,
    input  logic              mem_ready,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush,
    output logic              reg_EM_EN,
    output logic              reg_MW_EN,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    shadow_t ex_q, mem_q, wb_q;
    shadow_t id_ent;

    logic ex_ld_rs1, ex_ld_rs2;
    logic store_late_fix;
    logic load_use;
    logic freeze;
    logic stall;
    logic branch_flush;
    logic wb_rs2_unused;

    assign id_ent = '{optype: optype_e'(hazard_optype_ID), rd: rd_ID, rs2: rs2_ID};

    assign ex_ld_rs1 = (ex_q.optype == OP_LOAD) && (rs1_ID != '0) && (ex_q.rd == rs1_ID);
    assign ex_ld_rs2 = (ex_q.optype == OP_LOAD) && (rs2_ID != '0) && (ex_q.rd == rs2_ID);

    // Store data can wait: it is patched in MEM from the WB load result.
    assign store_late_fix = (hazard_optype_ID == OP_STORE) && ex_ld_rs2 && !ex_ld_rs1;

    assign load_use = (rs1use_ID && ex_ld_rs1) ||
                      (rs2use_ID && ex_ld_rs2 && !store_late_fix);

    assign freeze = ((mem_q.optype == OP_LOAD) || (mem_q.optype == OP_STORE)) && !mem_ready;

    assign stall        = load_use && !freeze;
    assign branch_flush = Branch_ID && !load_use && !freeze && !rst;

    assign PC_EN_IF     = !freeze && !load_use;
    assign reg_FD_EN    = !freeze && !load_use;
    assign reg_FD_flush = branch_flush;
    assign reg_DE_flush = stall;
    assign reg_EM_EN    = !freeze;
    assign reg_MW_EN    = !freeze;

    assign forward_ctrl_ls = (mem_q.optype == OP_STORE) && (wb_q.optype == OP_LOAD) &&
                             (mem_q.rs2 != '0) && (wb_q.rd == mem_q.rs2);

    assign wb_rs2_unused = ^wb_q.rs2;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs     (rs1_ID),
        .ex_op  (ex_q.optype),
        .ex_rd  (ex_q.rd),
        .mem_op (mem_q.optype),
        .mem_rd (mem_q.rd),
        .sel    (forward_ctrl_A)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs     (rs2_ID),
        .ex_op  (ex_q.optype),
        .ex_rd  (ex_q.rd),
        .mem_op (mem_q.optype),
        .mem_rd (mem_q.rd),
        .sel    (forward_ctrl_B)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= SHADOW_EMPTY;
            mem_q     <= SHADOW_EMPTY;
            wb_q      <= SHADOW_EMPTY;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (stall) begin
                ex_q <= SHADOW_EMPTY;
                if (stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                ex_q <= id_ent;
                if (branch_flush && (flush_cnt != '1)) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random bench for hazard_ctrl against an instruction-level pipeline model.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_ID, rs2_ID, rd_ID;
    logic          rs1use_ID, rs2use_ID;
    logic [1:0]    hazard_optype_ID;
    logic          Branch_ID, mem_ready;
    logic          PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, reg_EM_EN, reg_MW_EN;
    logic [1:0]    forward_ctrl_A, forward_ctrl_B;
    logic          forward_ctrl_ls;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .rs1_ID           (rs1_ID),
        .rs2_ID           (rs2_ID),
        .rd_ID            (rd_ID),
        .rs1use_ID        (rs1use_ID),
        .rs2use_ID        (rs2use_ID),
        .hazard_optype_ID (hazard_optype_ID),
        .Branch_ID        (Branch_ID),
        .mem_ready        (mem_ready),
        .PC_EN_IF         (PC_EN_IF),
        .reg_FD_EN        (reg_FD_EN),
        .reg_FD_flush     (reg_FD_flush),
        .reg_DE_flush     (reg_DE_flush),
        .reg_EM_EN        (reg_EM_EN),
        .reg_MW_EN        (reg_MW_EN),
        .forward_ctrl_A   (forward_ctrl_A),
        .forward_ctrl_B   (forward_ctrl_B),
        .forward_ctrl_ls  (forward_ctrl_ls),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instructions in flight: index 0 = EX, 1 = MEM, 2 = WB. op: 0 none, 1 alu, 2 load, 3 store.
    typedef struct {
        int op;
        int rd;
        int rs2;
    } ins_t;

    ins_t pipe [3];
    int   m_stall, m_flush;
    int   e_en, e_pipe_en, e_fdf, e_def, e_fa, e_fb, e_ls;
    bit   e_frz, e_lu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
        m_stall = 0;
        m_flush = 0;
    endtask

    // Youngest producer wins; a load still in EX cannot supply data yet.
    function automatic int fwd_of(int rs);
        if (rs == 0) return 0;
        for (int s = 0; s < 2; s++) begin
            if ((pipe[s].op == 1 || pipe[s].op == 2) && pipe[s].rd == rs) begin
                if (s == 0) return (pipe[s].op == 1) ? 1 : 0;
                return (pipe[s].op == 1) ? 2 : 3;
            end
        end
        return 0;
    endfunction

    task automatic model_eval();
        int r1;
        int r2;
        bit m1, m2, st_skip;
        r1 = int'(rs1_ID);
        r2 = int'(rs2_ID);
        e_frz = (pipe[1].op == 2 || pipe[1].op == 3) && !mem_ready;
        m1 = pipe[0].op == 2 && r1 != 0 && pipe[0].rd == r1;
        m2 = pipe[0].op == 2 && r2 != 0 && pipe[0].rd == r2;
        st_skip = (hazard_optype_ID == 2'd3) && m2 && !m1;
        e_lu = (rs1use_ID && m1) || (rs2use_ID && m2 && !st_skip);
        e_en      = (!e_frz && !e_lu) ? 1 : 0;
        e_pipe_en = e_frz ? 0 : 1;
        e_fdf     = (Branch_ID && !e_lu && !e_frz && !rst) ? 1 : 0;
        e_def     = (e_lu && !e_frz) ? 1 : 0;
        e_fa      = fwd_of(r1);
        e_fb      = fwd_of(r2);
        e_ls      = (pipe[1].op == 3 && pipe[2].op == 2 && pipe[1].rs2 != 0 &&
                     pipe[2].rd == pipe[1].rs2) ? 1 : 0;
    endtask

    task automatic check_all();
        model_eval();
        chk("pc_en",     PC_EN_IF,        e_en);
        chk("fd_en",     reg_FD_EN,       e_en);
        chk("fd_flush",  reg_FD_flush,    e_fdf);
        chk("de_flush",  reg_DE_flush,    e_def);
        chk("em_en",     reg_EM_EN,       e_pipe_en);
        chk("mw_en",     reg_MW_EN,       e_pipe_en);
        chk("fwd_a",     forward_ctrl_A,  e_fa);
        chk("fwd_b",     forward_ctrl_B,  e_fb);
        chk("fwd_ls",    forward_ctrl_ls, e_ls);
        chk("stall_cnt", stall_cnt,       m_stall);
        chk("flush_cnt", flush_cnt,       m_flush);
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (!e_frz) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e_lu) begin
                pipe[0] = '{0, 0, 0};
                if (m_stall < MAXC) m_stall++;
            end else begin
                pipe[0] = '{int'(hazard_optype_ID), int'(rd_ID), int'(rs2_ID)};
                if (Branch_ID && m_flush < MAXC) m_flush++;
            end
        end
    endtask

    task automatic set_id(int op, int rd, int r1, int r2, bit u1, bit u2, bit br);
        hazard_optype_ID = 2'(op);
        rd_ID            = AW'(rd);
        rs1_ID           = AW'(r1);
        rs2_ID           = AW'(r2);
        rs1use_ID        = u1;
        rs2use_ID        = u2;
        Branch_ID        = br;
    endtask

    // Inputs are already driven; check mid-cycle, then clock the model with the DUT.
    task automatic finish_cyc();
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 1);
        model_reset();
        #3;
        chk("rst_pc_en",    PC_EN_IF,       1);
        chk("rst_em_en",    reg_EM_EN,      1);
        chk("rst_fd_flush", reg_FD_flush,   0);
        chk("rst_fwd_a",    forward_ctrl_A, 0);
        chk("rst_stall",    stall_cnt,      0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        finish_cyc();

        // ALU producer forwarded from EX, then from MEM
        set_id(1, 5, 1, 2, 1, 1, 0); #3; finish_cyc();
        set_id(1, 6, 5, 5, 1, 1, 0); #3;
        chk("alu_ex_a", forward_ctrl_A, 1);
        chk("alu_ex_b", forward_ctrl_B, 1);
        chk("alu_ex_nostall", PC_EN_IF, 1);
        finish_cyc();
        set_id(1, 7, 5, 0, 1, 0, 0); #3;
        chk("alu_mem_a", forward_ctrl_A, 2);
        finish_cyc();

        // Load-use: one bubble, then load data from MEM
        set_id(2, 5, 1, 0, 1, 0, 0); #3; finish_cyc();
        set_id(1, 8, 5, 0, 1, 0, 0); #3;
        chk("lu_pc_en", PC_EN_IF, 0);
        chk("lu_de_flush", reg_DE_flush, 1);
        finish_cyc();
        #3;
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_memld_a", forward_ctrl_A, 3);
        chk("lu_resume", PC_EN_IF, 1);
        finish_cyc();

        // Load feeding store data: no stall, fixed up in MEM
        set_id(2, 5, 2, 0, 1, 0, 0); #3; finish_cyc();
        set_id(3, 0, 2, 5, 1, 1, 0); #3;
        chk("st_nostall", PC_EN_IF, 1);
        chk("st_fwd_b", forward_ctrl_B, 0);
        finish_cyc();
        set_id(0, 0, 0, 0, 0, 0, 0); #3; finish_cyc();
        #3;
        chk("st_ls", forward_ctrl_ls, 1);
        finish_cyc();

        // Branch flush, and branch held off by a load-use stall
        set_id(0, 0, 0, 0, 0, 0, 1); #3;
        chk("br_flush", reg_FD_flush, 1);
        finish_cyc();
        set_id(2, 9, 0, 0, 0, 0, 0); #3;
        chk("br_flush_cnt", flush_cnt, 1);
        finish_cyc();
        set_id(1, 10, 9, 0, 1, 0, 1); #3;
        chk("br_in_stall", reg_FD_flush, 0);
        finish_cyc();
        #3;
        chk("br_after_stall", reg_FD_flush, 1);
        finish_cyc();

        // Freeze on a pending load in MEM overrides branch
        set_id(2, 3, 0, 0, 0, 0, 0); #3; finish_cyc();
        set_id(0, 0, 0, 0, 0, 0, 0); #3; finish_cyc();
        mem_ready = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("frz_pc_en", PC_EN_IF, 0);
            chk("frz_mw_en", reg_MW_EN, 0);
            chk("frz_fd_flush", reg_FD_flush, 0);
            chk("frz_stall_cnt", stall_cnt, 2);
            chk("frz_flush_cnt", flush_cnt, 2);
            finish_cyc();
        end
        mem_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0); #3;
        chk("frz_resume", reg_EM_EN, 1);
        finish_cyc();

        // x0 is never a forwarding or stall source
        set_id(2, 0, 0, 0, 0, 0, 0); #3; finish_cyc();
        set_id(1, 0, 0, 0, 1, 1, 0); #3;
        chk("x0_nostall", PC_EN_IF, 1);
        finish_cyc();
        #3;
        chk("x0_fwd_a", forward_ctrl_A, 0);
        chk("x0_fwd_b", forward_ctrl_B, 0);
        finish_cyc();

        // Reset asserted in the middle of a stall
        set_id(2, 4, 0, 0, 0, 0, 0); #3; finish_cyc();
        set_id(1, 11, 4, 0, 1, 0, 0); #3;
        chk("mid_pre_pc_en", PC_EN_IF, 0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_pc_en", PC_EN_IF, 1);
        chk("mid_rst_de_flush", reg_DE_flush, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_flush", flush_cnt, 0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic over a small register set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0));
            mem_ready = ($urandom_range(0, 3) != 0);
            #3;
            finish_cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard scheduler for the 5-stage RV32I core (IF/ID/EX/MEM/WB; branches resolve in ID).
- Takes the ID-stage decode summary: rd, rs1/rs2, rs1use/rs2use, hazard_optype, Branch.
- Keeps its own shadow copy of the EX, MEM and WB occupants.
- From that state it produces PC/pipeline-register enable and flush controls, ID-stage forwarding selects and MEM-stage store-data forwarding.
- It also freezes the pipeline while the data memory is not ready.

Parameters:
REG_AW, 5, register-index width
CNT_W, 16, width of the stall/flush event counters

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
rs1_ID  in  REG_AW  ID source 1 index
rs2_ID  in  REG_AW  ID source 2 index
rd_ID  in  REG_AW  ID destination index
rs1use_ID  in  1  ID instruction reads rs1
rs2use_ID  in  1  ID instruction reads rs2
hazard_optype_ID  in  2  ID op class (package encoding)
Branch_ID  in  1  ID redirects PC (taken branch/JAL/JALR)
mem_ready  in  1  data memory completes MEM-stage access this cycle
PC_EN_IF  out  1  PC update enable
reg_FD_EN  out  1  IF/ID register enable
reg_FD_flush  out  1  IF/ID register clear
reg_DE_flush  out  1  ID/EX register clear (insert bubble)
reg_EM_EN  out  1  EX/MEM register enable
reg_MW_EN  out  1  MEM/WB register enable
forward_ctrl_A  out  2  rs1 operand select in ID
forward_ctrl_B  out  2  rs2 operand select in ID
forward_ctrl_ls  out  1  store data in MEM taken from WB load data
stall_cnt  out  CNT_W  load-use stall cycles since reset
flush_cnt  out  CNT_W  FD flushes since reset

Behaviour:
- Op classes: NONE 00, ALU 01 (R/I/LUI/AUIPC/JAL/JALR), LOAD 10, STORE 11.
- Writer = ALU or LOAD with rd≠0. x0 is never matched.
- Shadow state: EX, MEM and WB entries, each holding {optype, rd, rs2}. All clear to NONE/0 on rst asynchronously. Counters reset to 0.
- Reset-value outputs: enables 1, flushes 0, forward selects 0.
- Forward select encoding: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
  - Priority: an EX match beats a MEM match.
  - A WB match needs no forward (register file writes first half-cycle), so it gives 00.
- EX LOAD matching an ID source gives a load-use condition:
  - For rs1: when rs1use_ID.
  - For rs2: when rs2use_ID, except the case below.
  - Exception: ID is STORE, the match is on rs2 only, and rs1 does not match the EX load. Then there is no stall; forward_ctrl_B=00, and the value is corrected later via forward_ctrl_ls.
- forward_ctrl_ls=1 when MEM entry is STORE, WB entry is LOAD, and WB.rd==MEM.rs2≠0.
- Mem freeze: MEM entry is LOAD/STORE and mem_ready=0.
  - All enables 0, no flushes, shadow holds, counters hold.
  - The freeze overrides stall and branch.
- Load-use stall (no freeze): PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1.
  - The EX shadow loads NONE; MEM and WB shift normally.
  - stall_cnt increments, saturating.
- Branch_ID with no stall and no freeze: reg_FD_flush=1; flush_cnt increments, saturating.
  - Branch_ID during a load-use stall is ignored that cycle; it is re-evaluated once the operand is available.
- Normal cycle: all enables 1; shadow shifts ID→EX→MEM→WB.
  - The ID entry captures {hazard_optype_ID, rd_ID, rs2_ID}.
- Latency: all outputs are combinational from the inputs plus the shadow state. Shadow state updates on the rising clk edge.
- rst mid-operation clears all shadow entries immediately, so no stale forwards occur after release.

Decomposition:
- Package hazard_pkg holds: the optype constants (NONE/ALU/LOAD/STORE), the forward-select constants (FWD_RF/FWD_EX/FWD_MEM/FWD_MEMLD), and a shadow-entry struct.
- One sub-module, hazard_fwd_sel: combinational per-source forward selection. Instantiated twice, for A and B.

Test Plan:
- ALU x5 in EX, ID `add x6,x5,x5` → forward_ctrl_A=forward_ctrl_B=01, no stall. Next cycle (x5 in MEM) → 10.
- LOAD x5 in EX, ID uses rs1=x5 → one cycle with PC_EN_IF=0, reg_DE_flush=1, stall_cnt=1. Next cycle forward_ctrl_A=11.
- LOAD x5 then STORE with rs2=x5, rs1=x2 → no stall. Two cycles later forward_ctrl_ls=1.
- Branch_ID=1 with no hazard → reg_FD_flush=1, flush_cnt=1. Branch_ID=1 during a load-use stall → reg_FD_flush=0 that cycle.
- LOAD in MEM with mem_ready=0 for 3 cycles → all enables 0 for 3 cycles, shadow and counters unchanged. Resumes on mem_ready=1.
- Writer rd=x0 in EX, ID reads x0 → selects 00. Assert rst mid-stall → outputs return to reset values immediately and counters read 0.
